axi_rr_arbiter: RTL
===================

Name: axi_rr_arbiter

Overview:
- N-input round-robin arbiter that shares one axi_fifo write port (vld_in/rdy_in/data_in) among several rasterizer producers.
- Example producers: edge-walker lanes and per-tile fragment emitters.
- Grants whole bursts, bounded by a last flag or MAX_BURST beats, so beats from different requesters never interleave inside a burst.
- Tags each beat with the source ID so downstream logic can demultiplex.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 64, data width per requester.
- MAX_BURST, 8, maximum beats per grant before a forced release (>=1).
- ID_WIDTH, $clog2(NUM_REQ), width of the source ID.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- req_vld  input  NUM_REQ  per-requester valid.
- req_last  input  NUM_REQ  per-requester end-of-burst flag.
- req_data  input  NUM_REQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_rdy  output  NUM_REQ  per-requester ready.
- vld_out  output  1  valid to FIFO write side.
- data_out  output  WIDTH  muxed data.
- id_out  output  ID_WIDTH  index of the granted requester.
- last_out  output  1  last beat of the current grant (req_last or forced by MAX_BURST).
- rdy_out  input  1  ready from FIFO (its rdy_in).

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- On reset:
  - state=IDLE, prio_ptr=0, grant=0, beat_cnt=0.
  - vld_out=0, req_rdy=0, last_out=0.
  - data_out and id_out are don't-care while vld_out=0.
- Datapath is zero-latency. data_out, id_out, last_out and vld_out are muxed combinationally from the selected requester. No registering of data.
- Selected requester (sel):
  - IDLE: the first i with req_vld[i]=1, scanning prio_ptr, prio_ptr+1, ... mod NUM_REQ.
  - LOCKED: the registered grant.
- vld_out:
  - IDLE: OR of req_vld.
  - LOCKED: req_vld[grant].
- req_rdy[i] = rdy_out && vld_out && (i==sel). All other requesters see rdy=0.
- last_out = req_last[sel] || (beat_cnt == MAX_BURST-1).
- Beat accepted = vld_out && rdy_out.
- State machine (2 states):
  - IDLE, no requester valid: stay IDLE.
  - IDLE, sel chosen, beat accepted with last_out=1: stay IDLE; prio_ptr <= (sel+1) mod NUM_REQ.
  - IDLE, sel chosen, beat accepted with last_out=0: -> LOCKED; grant<=sel; beat_cnt<=1.
  - IDLE, sel chosen, no accept (rdy_out=0): -> LOCKED; grant<=sel; beat_cnt<=0. This freezes the mux so data_out stays stable until accepted (AXI stability rule).
  - LOCKED, accept with last_out=1: -> IDLE; prio_ptr <= (grant+1) mod NUM_REQ; beat_cnt<=0.
  - LOCKED, accept with last_out=0: beat_cnt<=beat_cnt+1.
  - LOCKED, req_vld[grant]=0: hold LOCKED. No other requester may fill the bubble.
- beat_cnt width is $clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1 while LOCKED.
- MAX_BURST=1: every accepted beat has last_out=1, giving pure per-beat round-robin.
- prio_ptr wrap: NUM_REQ-1 -> 0.
- Simultaneous requests: the lowest index at or after prio_ptr wins. Fairness: a continuously requesting lane waits at most NUM_REQ-1 bursts.
- rdy_out low for any duration: no state change except the IDLE->LOCKED freeze. beat_cnt does not advance.
- Reset mid-burst: the burst is abandoned. The requester sees req_rdy drop asynchronously. Arbitration restarts at prio_ptr=0.

Test Plan:
1. Single requester, single beat. req_vld=4'b0100, req_last[2]=1, data 0xAA, rdy_out=1 -> same cycle: vld_out=1, id_out=2, data_out=0xAA, last_out=1, req_rdy=4'b0100. Next cycle prio_ptr=3, state IDLE.
2. Round-robin fairness. All four requesters valid with last=1 every beat, rdy_out=1 for 8 cycles -> id_out sequence 0,1,2,3,0,1,2,3 and each req_rdy pulses once per 4 cycles.
3. Burst lock. Req0 sends 3 beats (last on beat 3) while req1 is valid throughout -> id_out=0,0,0 then 1. req_rdy[1]=0 during the req0 burst. Req0 drops vld for 2 cycles mid-burst -> vld_out=0 and req1 is still not granted.
4. MAX_BURST force. MAX_BURST=8, req1 streams 12 beats with req_last=0 and req2 also valid -> last_out=1 on beat 8, grant passes to req2, req1 resumes after req2's burst.
5. Backpressure stability. Req3 valid, rdy_out=0 for 5 cycles, req0 asserts on cycle 2 -> id_out stays 3 and data_out is unchanged. On rdy_out=1 the req3 beat is accepted first.
6. Async reset mid-burst. Assert rst during beat 2 of a req1 burst, between clock edges -> vld_out and req_rdy go to 0 immediately. After release, with all requesters valid, the first grant is id 0.

Source files
------------

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers. It grants whole bursts, which end on req_last or after
// MAX_BURST beats, and tags each beat with the index of its source.
//
// Ports:
//   clk       clock
//   rst       asynchronous reset, active-high
//   req_vld   per-requester valid
//   req_last  per-requester end-of-burst flag
//   req_data  packed requester data, lane i at [i*WIDTH +: WIDTH]
//   req_rdy   per-requester ready (only the selected lane can see it high)
//   vld_out   valid to the FIFO write side
//   data_out  data muxed from the selected lane
//   id_out    index of the selected lane
//   last_out  last beat of the grant (req_last or MAX_BURST reached)
//   rdy_out   ready from the FIFO
module axi_rr_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned MAX_BURST = 8,
   parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_vld,
   input  logic [NUM_REQ-1:0]       req_last,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_rdy,
   output logic                     vld_out,
   output logic [WIDTH-1:0]         data_out,
   output logic [ID_WIDTH-1:0]      id_out,
   output logic                     last_out,
   input  logic                     rdy_out
);

   localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_BURST - 1);
   localparam logic [ID_WIDTH-1:0]  ID_MAX   = ID_WIDTH'(NUM_REQ - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t               state;
   logic [ID_WIDTH-1:0]  prio_ptr;
   logic [ID_WIDTH-1:0]  grant;
   logic [CNT_WIDTH-1:0] beat_cnt;

   logic [WIDTH-1:0]     lane_data [NUM_REQ];
   logic [ID_WIDTH-1:0]  cand;
   logic [ID_WIDTH-1:0]  rr_sel;
   logic                 rr_any;
   logic [ID_WIDTH-1:0]  sel;
   logic                 accept;

   // Unpack the flat data bus into per-lane words
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      assign lane_data[g] = req_data[g*WIDTH +: WIDTH];
   end

   // Round-robin pick: first valid lane at or after prio_ptr
   always_comb begin
      cand   = prio_ptr;
      rr_sel = prio_ptr;
      rr_any = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = ID_WIDTH'((32'(prio_ptr) + k) % NUM_REQ);
         if (!rr_any && req_vld[cand]) begin
            rr_any = 1'b1;
            rr_sel = cand;
         end
      end
   end

   // Once locked the mux is frozen on the grant, so a stalled beat stays stable
   assign sel = (state == LOCKED) ? grant : rr_sel;

   // Zero-latency output mux; reset forces the handshake low at once
   always_comb begin
      vld_out  = !rst && ((state == LOCKED) ? req_vld[grant] : rr_any);
      data_out = lane_data[sel];
      id_out   = sel;
      last_out = vld_out && (req_last[sel] || (beat_cnt == CNT_LAST));
      accept   = vld_out && rdy_out;
   end

   // Ready goes only to the lane being passed through
   always_comb begin
      req_rdy = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (sel == ID_WIDTH'(i)) begin
            req_rdy[i] = accept;
         end
      end
   end

   function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] p);
      return (p == ID_MAX) ? '0 : p + 1'b1;
   endfunction

   // Arbitration state: burst lock, beat counting and priority rotation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         prio_ptr <= '0;
         grant    <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rr_any) begin
                  if (rdy_out) begin
                     if (last_out) begin
                        prio_ptr <= next_ptr(rr_sel);
                     end else begin
                        state    <= LOCKED;
                        grant    <= rr_sel;
                        beat_cnt <= CNT_WIDTH'(1);
                     end
                  end else begin
                     // Stalled first beat: lock so the offered data cannot change
                     state    <= LOCKED;
                     grant    <= rr_sel;
                     beat_cnt <= '0;
                  end
               end
            end
            LOCKED: begin
               if (accept) begin
                  if (last_out) begin
                     state    <= IDLE;
                     prio_ptr <= next_ptr(grant);
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
